// File: rtl/led_breathe_if.sv
// Control/status bundle between the breathing-LED driver and its user.
// Latency: none, wires only.
// Backpressure: none; en gates the driver, step_in is sampled every cycle.
interface led_breathe_if #(
   parameter int PWM_BITS = 8
);
   logic                en;
   logic                step_in;
   logic                led;
   logic [PWM_BITS-1:0] duty;
   logic [1:0]          state;

   modport master (output en, output step_in, input led, input duty, input state);
   modport slave  (input en, input step_in, output led, output duty, output state);
endinterface

// File: rtl/led_breathe.sv
// LED breathing driver: ramps a PWM duty up/hold/down/hold, one move per rising step_in edge.
// Latency: duty/state update on the edge sampling the step; led follows duty one cycle later.
// Backpressure: en=0 freezes FSM/duty/PWM and forces led low; steps seen while disabled are dropped.
module led_breathe #(
   parameter int PWM_BITS   = 8,
   parameter int STEP       = 8,
   parameter int HOLD_STEPS = 4
) (
   input logic         clk,
   input logic         rst_n,
   led_breathe_if.slave bus
);

   localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
   localparam logic [PWM_BITS-1:0] DMAX      = '1;
   localparam logic [PWM_BITS:0]   DMAX_X    = {1'b0, DMAX};
   localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS+1)'(STEP);
   localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_STEPS - 1);

   typedef enum logic [1:0] {
      LOW_HOLD  = 2'd0,
      RAMP_UP   = 2'd1,
      HIGH_HOLD = 2'd2,
      RAMP_DOWN = 2'd3
   } state_t;

   state_t              state_q, state_nxt;
   logic [PWM_BITS-1:0] duty_q, duty_nxt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [HW-1:0]       hold_cnt, hold_nxt;
   logic [PWM_BITS:0]   sum;
   logic                step_q, step, adv, hold_done, led_q;

   // step_q resets high so a step_in already high at release is not an edge
   assign step      = bus.step_in & ~step_q;
   assign adv       = step & bus.en;
   assign sum       = {1'b0, duty_q} + STEP_X;
   assign hold_done = (hold_cnt == HOLD_LAST);

   // edge-detect history, tracked regardless of en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) step_q <= 1'b1;
      else        step_q <= bus.step_in;
   end

   // free-running PWM counter and registered LED compare
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         led_q   <= 1'b0;
      end else begin
         led_q <= bus.en & (pwm_cnt < duty_q);
         if (bus.en) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= LOW_HOLD;
      else        state_q <= state_nxt;
   end

   // FSM next-state decision, moves only on an enabled step
   always_comb begin
      state_nxt = state_q;
      if (adv) begin
         case (state_q)
            LOW_HOLD:  if (hold_done)                state_nxt = RAMP_UP;
            RAMP_UP:   if (sum >= DMAX_X)            state_nxt = HIGH_HOLD;
            HIGH_HOLD: if (hold_done)                state_nxt = RAMP_DOWN;
            RAMP_DOWN: if ({1'b0, duty_q} <= STEP_X) state_nxt = LOW_HOLD;
         endcase
      end
   end

   // FSM outputs: saturating duty and hold counting
   always_comb begin
      duty_nxt = duty_q;
      hold_nxt = hold_cnt;
      if (adv) begin
         case (state_q)
            LOW_HOLD, HIGH_HOLD: hold_nxt = hold_done ? '0 : hold_cnt + HW'(1);
            RAMP_UP:   duty_nxt = (sum >= DMAX_X) ? DMAX : sum[PWM_BITS-1:0];
            RAMP_DOWN: duty_nxt = ({1'b0, duty_q} <= STEP_X) ? '0
                                  : duty_q - STEP_X[PWM_BITS-1:0];
         endcase
      end
   end

   // duty and hold counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q   <= '0;
         hold_cnt <= '0;
      end else begin
         duty_q   <= duty_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   assign bus.led   = led_q;
   assign bus.duty  = duty_q;
   assign bus.state = state_q;

endmodule

// File: tb/tb_led_breathe.sv
// Bench for led_breathe: two instances (STEP=8 and STEP=200) share stimulus.
// Latency: model tracks each cycle; outputs compared on every falling edge out of reset.
// Backpressure: en toggled directly and randomly; no handshake involved.
module tb_led_breathe;

   localparam int DMAX = 255;
   localparam int HOLD = 4;
   int STEPV [2] = '{8, 200};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic step_in = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   led_breathe_if #(.PWM_BITS(8)) b0 ();
   led_breathe_if #(.PWM_BITS(8)) b1 ();

   assign b0.en      = en;
   assign b0.step_in = step_in;
   assign b1.en      = en;
   assign b1.step_in = step_in;

   led_breathe #(.PWM_BITS(8), .STEP(8), .HOLD_STEPS(4)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(b0));
   led_breathe #(.PWM_BITS(8), .STEP(200), .HOLD_STEPS(4)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(b1));

   // behavioural reference: phase, duty level, hold count, PWM phase
   int m_st [2];
   int m_duty [2];
   int m_hold [2];
   int m_pwm [2];
   bit m_led [2];
   bit m_stepq;
   bit m_stp;
   bit m_ledn;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_duty[i] = 0; m_hold[i] = 0; m_pwm[i] = 0; m_led[i] = 0;
         end
         m_stepq = 1;
      end else begin
         m_stp = step_in && !m_stepq;
         for (int i = 0; i < 2; i++) begin
            m_ledn = en && (m_pwm[i] < m_duty[i]);
            if (en) m_pwm[i] = (m_pwm[i] + 1) % (DMAX + 1);
            if (m_stp && en) begin
               case (m_st[i])
                  0, 2: begin
                     m_hold[i] = m_hold[i] + 1;
                     if (m_hold[i] == HOLD) begin
                        m_hold[i] = 0;
                        m_st[i] = m_st[i] + 1;
                     end
                  end
                  1: begin
                     m_duty[i] = (m_duty[i] + STEPV[i] > DMAX) ? DMAX : m_duty[i] + STEPV[i];
                     if (m_duty[i] == DMAX) m_st[i] = 2;
                  end
                  default: begin
                     m_duty[i] = (m_duty[i] > STEPV[i]) ? m_duty[i] - STEPV[i] : 0;
                     if (m_duty[i] == 0) m_st[i] = 0;
                  end
               endcase
            end
            m_led[i] = m_ledn;
         end
         m_stepq = step_in;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("u0_led",   int'(b0.led),   int'(m_led[0]));
         chk("u0_duty",  int'(b0.duty),  m_duty[0]);
         chk("u0_state", int'(b0.state), m_st[0]);
         chk("u1_led",   int'(b1.led),   int'(m_led[1]));
         chk("u1_duty",  int'(b1.duty),  m_duty[1]);
         chk("u1_state", int'(b1.state), m_st[1]);
      end
   end

   task automatic pulse();
      step_in = 1'b1;
      repeat (2) @(negedge clk);
      step_in = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   int hi;

   initial begin
      // reset values
      repeat (3) @(negedge clk);
      chk("rst_duty", int'(b0.duty), 0);
      chk("rst_state", int'(b0.state), 0);
      chk("rst_led", int'(b0.led), 0);
      rst_n = 1'b1;
      en = 1'b1;
      @(negedge clk);

      // a long high level is a single step
      step_in = 1'b1;
      repeat (100) @(negedge clk);
      step_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("level_one_step_state", int'(b0.state), 0);
      repeat (2) pulse();
      chk("hold3_state", int'(b0.state), 0);
      pulse();
      chk("hold_to_ramp_state", int'(b0.state), 1);

      // first ramp steps; STEP=200 saturates on its second step
      pulse();
      chk("ramp1_duty_u0", int'(b0.duty), 8);
      chk("ramp1_duty_u1", int'(b1.duty), 200);
      pulse();
      chk("sat_up_duty_u1", int'(b1.duty), 255);
      chk("sat_up_state_u1", int'(b1.state), 2);
      repeat (3) pulse();
      chk("duty40_u0", int'(b0.duty), 40);

      // enable low: led off, steps lost
      en = 1'b0;
      @(negedge clk);
      chk("en_off_led", int'(b0.led), 0);
      repeat (3) pulse();
      chk("en_off_duty", int'(b0.duty), 40);
      chk("en_off_state", int'(b0.state), 1);
      en = 1'b1;
      pulse();
      chk("en_on_duty", int'(b0.duty), 48);
      chk("hh_to_down_u1", int'(b1.state), 3);
      pulse();
      chk("duty56_u0", int'(b0.duty), 56);
      chk("sat_down1_u1", int'(b1.duty), 55);
      pulse();
      chk("duty64_u0", int'(b0.duty), 64);
      chk("sat_down0_u1", int'(b1.duty), 0);
      chk("sat_down_state_u1", int'(b1.state), 0);

      // PWM: 64 high cycles per 256 at duty 64
      hi = 0;
      repeat (256) begin
         @(negedge clk);
         if (b0.led) hi++;
      end
      chk("pwm64_high_cycles", hi, 64);

      // complete the loop
      repeat (23) pulse();
      chk("ramp31_duty", int'(b0.duty), 248);
      pulse();
      chk("ramp32_duty", int'(b0.duty), 255);
      chk("ramp32_state", int'(b0.state), 2);
      repeat (4) pulse();
      chk("hh_done_state", int'(b0.state), 3);
      pulse();
      chk("down1_duty", int'(b0.duty), 247);
      repeat (30) pulse();
      chk("down31_duty", int'(b0.duty), 7);
      pulse();
      chk("down32_duty", int'(b0.duty), 0);
      chk("down32_state", int'(b0.state), 0);

      // asynchronous reset mid-ramp with step_in high at release
      repeat (7) pulse();
      chk("pre_rst_duty", int'(b0.duty), 24);
      step_in = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_duty", int'(b0.duty), 0);
      chk("async_rst_state", int'(b0.state), 0);
      chk("async_rst_led", int'(b0.led), 0);
      chk("async_rst_duty_u1", int'(b1.duty), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      step_in = 1'b0;
      repeat (2) @(negedge clk);
      repeat (3) pulse();
      chk("no_step_at_release", int'(b0.state), 0);
      pulse();
      chk("post_rst_ramp", int'(b0.state), 1);

      // randomized enable and step waveform, checked by the model
      repeat (15000) begin
         @(negedge clk);
         en = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 2) == 0) step_in = ~step_in;
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
